proc_dispatcher: RTL and testbench

//   Sequences SIMD processor array: accepts one command at a time from the issue path,

---
 rtl/simd_pkg.sv | 22 ++
 rtl/proc_dispatcher_rr_arbiter.sv | 35 +++
 rtl/proc_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_proc_dispatcher.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD processor dispatcher.
package simd_pkg;

  // Dispatcher sequencing states: waiting for a command, or streaming its beats.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BEAT = 1'b1
  } disp_state_t;

  // A command is always split into exactly this many instruction beats.
  localparam int NUM_BEATS = 4;

  // Default processor count; the dispatcher itself is parameterised.
  localparam int PROC_COUNT_DEF = 4;

  typedef logic [1:0] beat_idx_t;
  typedef logic [$clog2(PROC_COUNT_DEF)-1:0] proc_idx_t;

  // Index of the final beat (WRITE) of a command.
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(NUM_BEATS - 1);

endpackage

// File: rtl/proc_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request mask starting at the
// pointer position, wrapping from N-1 back to 0, and returns the first hit as a
// one-hot grant plus its index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  int idx_s;

  // Priority search from the pointer; the first requesting slot found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx_s     = 0;
    for (int i = 0; i < N; i++) begin
      idx_s = ((int'(ptr) + i) >= N) ? (int'(ptr) + i - N) : (int'(ptr) + i);
      if (!valid && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = IW'(idx_s);
        valid        = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/proc_dispatcher.sv
// SIMD processor dispatcher: accepts one command at a time, picks a free
// processor round-robin, streams the command as four acked instruction beats
// and tracks each processor's outstanding work until it reports finish.
// Optional feature macro: DISPATCH_TIMEOUT_EN -- abort a beat that is not
// acknowledged within ACK_TIMEOUT cycles and pulse o_timeout.
module proc_dispatcher
  import simd_pkg::*;
#(
  parameter int PROC_COUNT  = 4,
  parameter int INSTR_W     = 32,
  parameter int CMD_W       = 4 * INSTR_W,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cmd_valid,
  input  logic [CMD_W-1:0]      i_cmd,
  output logic                  o_cmd_ready,
  input  logic [PROC_COUNT-1:0] i_busy,
  input  logic [PROC_COUNT-1:0] i_finish,
  input  logic                  i_ack,
  output logic [PROC_COUNT-1:0] o_en_arr,
  output logic [INSTR_W-1:0]    o_instr,
  output logic                  o_instr_valid,
  output logic [PROC_COUNT-1:0] o_done_mask,
  output logic [PROC_COUNT-1:0] o_pending,
  output logic                  o_timeout
);

  localparam int IW = $clog2(PROC_COUNT);

  // Reject configurations the datapath cannot represent.
  if (PROC_COUNT < 2) begin : g_bad_proc_count
    $error("proc_dispatcher: PROC_COUNT must be at least 2");
  end
  if (CMD_W != NUM_BEATS * INSTR_W) begin : g_bad_cmd_w
    $error("proc_dispatcher: CMD_W must equal 4*INSTR_W");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("proc_dispatcher: ACK_TIMEOUT must fit the 8-bit beat counter");
  end

  disp_state_t           state_r, state_s;
  beat_idx_t             beat_r, beat_s;
  logic [CMD_W-1:0]      cmd_r;
  logic [PROC_COUNT-1:0] grant_r;
  logic [PROC_COUNT-1:0] pending_r, pending_s;
  logic [PROC_COUNT-1:0] done_mask_r;
  logic [IW-1:0]         rr_ptr_r;
  logic [PROC_COUNT-1:0] eligible_s;
  logic [PROC_COUNT-1:0] arb_grant_s;
  logic [IW-1:0]         arb_idx_s;
  logic                  arb_valid_s;
  logic                  accept_s;
  logic                  abort_s;

  assign eligible_s  = ~i_busy & ~pending_r;
  assign o_cmd_ready = (state_r == IDLE) & arb_valid_s;
  assign accept_s    = i_cmd_valid & o_cmd_ready;

  rr_arbiter #(
    .N  (PROC_COUNT),
    .IW (IW)
  ) u_arb (
    .req       (eligible_s),
    .ptr       (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .valid     (arb_valid_s)
  );

  // Next-state logic: accept moves to the first beat; each ack advances one beat.
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = BEAT;
          beat_s  = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      BEAT: begin
        if (i_ack) begin
          if (beat_r == LAST_BEAT) begin
            state_s = IDLE;
            beat_s  = 2'd0;
          end else begin
            beat_s = beat_r + 2'd1;
          end
        end else if (abort_s) begin
          state_s = IDLE;
          beat_s  = 2'd0;
        end else begin
          state_s = BEAT;
        end
      end
      default: begin
        state_s = IDLE;
        beat_s  = 2'd0;
      end
    endcase
  end

  // Outstanding work: finishes and aborts clear, a new grant sets (set wins).
  always_comb begin
    pending_s = ((pending_r & ~i_finish) & ~(abort_s ? grant_r : {PROC_COUNT{1'b0}}))
              | (accept_s ? arb_grant_s : {PROC_COUNT{1'b0}});
  end

  // Control and datapath registers; command and grant are captured on accept.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r     <= IDLE;
      beat_r      <= 2'd0;
      cmd_r       <= '0;
      grant_r     <= '0;
      pending_r   <= '0;
      done_mask_r <= '0;
      rr_ptr_r    <= '0;
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_s;
      pending_r   <= pending_s;
      done_mask_r <= i_finish & pending_r;
      if (accept_s) begin
        cmd_r    <= i_cmd;
        grant_r  <= arb_grant_s;
        rr_ptr_r <= (arb_idx_s == IW'(PROC_COUNT - 1)) ? {IW{1'b0}} : (arb_idx_s + IW'(1));
      end
    end
  end

  // Beat presentation is a pure decode of registered state.
  always_comb begin
    if (state_r == BEAT) begin
      o_en_arr      = grant_r;
      o_instr_valid = 1'b1;
      o_instr       = cmd_r[int'(beat_r) * INSTR_W +: INSTR_W];
    end else begin
      o_en_arr      = '0;
      o_instr_valid = 1'b0;
      o_instr       = '0;
    end
  end

  assign o_done_mask = done_mask_r;
  assign o_pending   = pending_r;

`ifdef DISPATCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [7:0] to_cnt_r;
  logic       timeout_r;

  assign abort_s = (state_r == BEAT) & ~i_ack & (to_cnt_r == TO_LAST);

  // Per-beat ack watchdog: restarts on every beat entry, counts unacked cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      to_cnt_r  <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= abort_s;
      if ((state_r != BEAT) || i_ack || abort_s) begin
        to_cnt_r <= 8'd0;
      end else begin
        to_cnt_r <= to_cnt_r + 8'd1;
      end
    end
  end

  assign o_timeout = timeout_r;
`else
  assign abort_s   = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_proc_dispatcher.sv
// Scoreboard bench for proc_dispatcher: stimulus pushes expected beats and
// finish reports into queues, a negedge monitor compares whatever the DUT presents.
module tb_proc_dispatcher;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  typedef struct packed {
    logic [3:0]  en;
    logic [31:0] instr;
  } beat_t;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic         i_cmd_valid;
  logic [127:0] i_cmd;
  logic         o_cmd_ready;
  logic [3:0]   i_busy;
  logic [3:0]   i_finish;
  logic         i_ack;
  logic [3:0]   o_en_arr;
  logic [31:0]  o_instr;
  logic         o_instr_valid;
  logic [3:0]   o_done_mask;
  logic [3:0]   o_pending;
  logic         o_timeout;

  beat_t      exp_q[$];
  logic [3:0] done_q[$];
  logic [3:0] exp_pend;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  proc_dispatcher #(
    .PROC_COUNT  (4),
    .INSTR_W     (32),
    .CMD_W       (128),
    .ACK_TIMEOUT (TO)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd         (i_cmd),
    .o_cmd_ready   (o_cmd_ready),
    .i_busy        (i_busy),
    .i_finish      (i_finish),
    .i_ack         (i_ack),
    .o_en_arr      (o_en_arr),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .o_done_mask   (o_done_mask),
    .o_pending     (o_pending),
    .o_timeout     (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_evt(input string nm);
    total_cnt++;
    $display("FAIL %s: DUT output with no expected entry queued", nm);
  endtask

  // One clock: inputs change and direct checks happen 1 time unit after posedge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one command and ack its beats; dly nibble k = idle cycles before ack of beat k.
  task automatic send(input logic [127:0] cmd, input logic [3:0] exp_en, input logic [15:0] dly);
    chk("ready_before_accept", o_cmd_ready, 1'b1);
    for (int k = 0; k < 4; k++) exp_q.push_back({exp_en, cmd[k*32 +: 32]});
    i_cmd_valid = 1'b1;
    i_cmd       = cmd;
    i_ack       = 1'b1;   // ack while idle must be ignored
    step();
    i_cmd_valid = 1'b0;
    i_cmd       = '0;
    chk("ready_during_beats", o_cmd_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      i_ack = 1'b0;
      repeat (int'(dly[k*4 +: 4])) step();
      i_ack = 1'b1;
      step();
    end
    i_ack = 1'b0;
    chk("idle_after_write", o_instr_valid, 1'b0);
  endtask

  // Monitor: every presented beat must match the queue head; done reports likewise.
  always @(negedge i_clk) begin
    if (i_rstn === 1'b1) begin
      if (o_instr_valid) begin
        if (exp_q.size() == 0) fail_evt("beat_unexpected");
        else begin
          chk("beat_en", o_en_arr, exp_q[0].en);
          chk("beat_instr", o_instr, exp_q[0].instr);
          if (i_ack) void'(exp_q.pop_front());
        end
      end
      if (o_done_mask != 4'b0000) begin
        if (done_q.size() == 0) fail_evt("done_unexpected");
        else chk("done_mask", o_done_mask, done_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  seen;
    i_rstn = 1'b0; i_cmd_valid = 1'b0; i_cmd = '0;
    i_busy = 4'b0000; i_finish = 4'b0000; i_ack = 1'b0;
    step(); step();
    chk("rst_en", o_en_arr, 4'b0000);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_valid", o_instr_valid, 1'b0);
    chk("rst_done", o_done_mask, 4'b0000);
    chk("rst_pending", o_pending, 4'b0000);
    chk("rst_timeout", o_timeout, 1'b0);
    i_rstn = 1'b1;

    // Single command to an idle array.
    send(128'h44444444_33333333_22222222_11111111, 4'b0001, 16'h0000);
    exp_pend = 4'b0001;
    chk("t1_pending", o_pending, exp_pend);

    // Back-to-back round robin, last grant forced by busy flags.
    send(128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 4'b0010, 16'h0000);
    send(128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1, 4'b0100, 16'h0000);
    i_busy = 4'b0111;
    send(128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1, 4'b1000, 16'h0000);
    exp_pend = 4'b1111;
    chk("t2_pending", o_pending, exp_pend);
    chk("t2_ready_none_eligible", o_cmd_ready, 1'b0);
    i_busy = 4'b0000;
    chk("t2_ready_all_pending", o_cmd_ready, 1'b0);

    // Simultaneous finishes, then a stray finish, then the rest.
    done_q.push_back(4'b0011);
    i_finish = 4'b0011; step(); i_finish = 4'b0000;
    exp_pend = 4'b1100;
    chk("t4_pending", o_pending, exp_pend);
    chk("t4_ready", o_cmd_ready, 1'b1);
    step();
    i_finish = 4'b0001; step(); i_finish = 4'b0000;
    chk("t4_stray_done", o_done_mask, 4'b0000);
    chk("t4_stray_pending", o_pending, exp_pend);
    done_q.push_back(4'b1100);
    i_finish = 4'b1100; step(); i_finish = 4'b0000;
    exp_pend = 4'b0000;
    chk("t4_pending_clear", o_pending, exp_pend);
    step();

    // Pointer wrapped to 0 but proc 0 busy -> proc 1; beat 2 held 3 extra cycles.
    i_busy = 4'b0001;
    send(128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 4'b0010, 16'h0300);
    i_busy = 4'b0000;
    exp_pend = 4'b0010;
    chk("t3_pending", o_pending, exp_pend);

    // Reset in the middle of beat 2 abandons the transfer.
    for (int k = 0; k < 3; k++) exp_q.push_back({4'b0100, 32'hE1E1E1E1 + 32'(k) * 32'h01010101});
    i_cmd_valid = 1'b1; i_cmd = 128'hE4E4E4E4_E3E3E3E3_E2E2E2E2_E1E1E1E1;
    step();
    i_cmd_valid = 1'b0; i_cmd = '0; i_ack = 1'b1;
    step(); step();
    i_ack = 1'b0;
    chk("t5_beat2_shown", o_instr, 32'hE3E3E3E3);
    step();
    i_rstn = 1'b0;
    step();
    exp_q.delete();
    chk("t5_en", o_en_arr, 4'b0000);
    chk("t5_valid", o_instr_valid, 1'b0);
    chk("t5_instr", o_instr, 32'h0);
    chk("t5_pending", o_pending, 4'b0000);
    chk("t5_timeout", o_timeout, 1'b0);
    i_rstn = 1'b1;
    send(128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1, 4'b0001, 16'h0000);
    exp_pend = 4'b0001;
    chk("t5_restart_pending", o_pending, exp_pend);

    // No ack at all on a command to proc 1.
    for (int k = 0; k < 4; k++) exp_q.push_back({4'b0010, 32'h55555551 + 32'(k)});
    i_cmd_valid = 1'b1; i_cmd = 128'h55555554_55555553_55555552_55555551;
    step();
    i_cmd_valid = 1'b0; i_cmd = '0;
`ifdef DISPATCH_TIMEOUT_EN
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (o_timeout && n == 0) n = c;
    end
    chk("t6_timeout_cycle", n, 10);
    chk("t6_pending", o_pending, 4'b0001);
    chk("t6_idle", o_instr_valid, 1'b0);
    chk("t6_pulse_over", o_timeout, 1'b0);
    exp_q.delete();
`else
    seen = 1'b0;
    repeat (1000) begin
      step();
      if (o_timeout) seen = 1'b1;
    end
    chk("t6_no_timeout", seen, 1'b0);
    chk("t6_still_waiting", o_instr_valid, 1'b1);
    chk("t6_pending_held", o_pending, 4'b0011);
    i_rstn = 1'b0;
    step();
    exp_q.delete();
    i_rstn = 1'b1;
    chk("t6_pending_after_rst", o_pending, 4'b0000);
`endif
    step();
    chk("beat_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
